// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_pkg;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    localparam int   DATA_BITS       = 8;
    localparam int   FRAME_BITS_BASE = 10;
    localparam logic TX_IDLE         = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: tick marks the last clk of a bit, tick_early the clk before it.
// Held at zero while clear is high so each frame starts on a fresh bit boundary.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_early
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] EARLY = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick       = (cnt_q == LAST)  && !clear;
    assign tick_early = (cnt_q == EARLY) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an 8-bit FIFO and sends them as UART frames (start, 8 data LSB-first, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 16,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d;
    logic       rd_en_q, rd_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick, tick_early, baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear     (baud_clear),
        .tick      (tick),
        .tick_early(tick_early)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            // The strobe is decided one clk ahead so it leaves a flop; FETCH follows the strobe clk.
            ST_IDLE: begin
                if (rd_en_q) begin
                    state_d = ST_FETCH;
                end else if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                shift_d = fifo_data;
                idx_d   = '0;
                state_d = ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            // Leaving STOP straight into a strobing IDLE clk gives back-to-back frames.
            ST_STOP: begin
                done_d = tick_early;
                if (tick) begin
                    state_d = ST_IDLE;
                    rd_en_d = !fifo_empty;
                    busy_d  = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_d = TX_IDLE;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= TX_IDLE;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
